apb_sram_completer: RTL
=======================

Name: apb_sram_completer

Overview:
APB3 completer (slave) that answers the transfers issued by the team's APB master: decodes PSEL/PENABLE/PWRITE, stores writes in an internal SRAM array and returns read data with a handshaked PREADY. It inserts programmable wait states and flags out-of-range addresses on PSLVERR. It replaces the always-ready SRAM slave, so the master's pready input is driven by real logic.

Parameters:
ADDR_W, 8, PADDR width
DATA_W, 8, PWDATA/PRDATA width
DEPTH, 64, number of SRAM words; any address >= DEPTH is an error
WAIT_CYCLES, 2, wait states inserted before PREADY (range 0..15; used only with APB_WAIT_EN)

Ports:
PCLK  input  1  system clock, rising edge
PRESET  input  1  reset, asynchronous, active-high
PSEL  input  1  completer select
PENABLE  input  1  access phase indicator
PWRITE  input  1  1 = write, 0 = read
PADDR  input  ADDR_W  transfer address
PWDATA  input  DATA_W  write data
PREADY  output  1  transfer completes on an edge where PSEL & PENABLE & PREADY
PRDATA  output  DATA_W  read data, valid while PREADY=1 on a read
PSLVERR  output  1  error response, valid only while PREADY=1
busy  output  1  high from the setup edge until completion

Behaviour:
- Reset (async, PRESET=1):
  - state=IDLE; PREADY=0, PSLVERR=0, PRDATA=0, busy=0, wait counter=0.
  - SRAM contents are not reset.
- States: IDLE, ACCESS. All outputs are registered.
- IDLE, on an edge with PSEL=1 & PENABLE=0 (setup):
  - latch PADDR, PWRITE, PWDATA; err = (PADDR >= DEPTH); busy<=1; go to ACCESS.
  - counter <= WAIT_CYCLES.
  - If WAIT_CYCLES==0: PREADY<=1 in the same edge, so the first access cycle completes with zero waits.
- ACCESS with PREADY=0:
  - counter decrements each edge.
  - On the edge where counter==1: PREADY<=1.
- Read data and error are loaded on the same edge that sets PREADY:
  - PSLVERR <= err.
  - Read: PRDATA <= err ? 0 : mem[addr].
  - Write: PRDATA holds its value.
- Completion edge (PSEL & PENABLE & PREADY):
  - Write with err=0: mem[addr] <= latched PWDATA.
  - Write with err=1: no SRAM update.
  - PREADY<=0, PSLVERR<=0, busy<=0, state -> IDLE. PRDATA holds.
- Back-to-back: the next setup is sampled in IDLE on the cycle after completion, giving the minimum 2 cycles per transfer.
- Latched values are used, so changes to PADDR/PWDATA during ACCESS are ignored.
- Abort: PSEL=0 while in ACCESS returns to IDLE, clears PREADY/PSLVERR/busy, and performs no write.
- Restart: PSEL=1 & PENABLE=0 while in ACCESS is treated as a fresh setup (re-latch, reload counter).
- Reset mid-transfer: transfer is dropped and no write occurs.
- Address width: PADDR is used unmodified; no wrap-around. DEPTH=2^ADDR_W disables error generation.

Optional Feature:
APB_WAIT_EN
- Defined: wait-state counter is built and WAIT_CYCLES is honoured.
- Undefined: counter logic is removed; behaves as WAIT_CYCLES=0 (PREADY in the first access cycle) regardless of the parameter.

Decomposition:
- Package apb_pkg holds:
  - state enum (IDLE, ACCESS)
  - default widths APB_ADDR_W=8, APB_DATA_W=8
  - error response constant APB_ERR_RDATA=0
- One sub-module, apb_sram_array:
  - DEPTH x DATA_W storage, one synchronous write port, one combinational read port.
  - Instantiated once. The completer owns all protocol and handshake logic.

Test Plan:
1. Reset: assert PRESET mid-cycle -> PREADY=0, PSLVERR=0, PRDATA=0 immediately, without waiting for a clock.
2. Write then read, WAIT_CYCLES=2 with APB_WAIT_EN:
   - Stimulus: write 0xA5 to addr 0x10, then read 0x10.
   - Response: PREADY rises on the 3rd access cycle of each transfer; PRDATA=0xA5; PSLVERR=0.
3. Zero wait, APB_WAIT_EN undefined:
   - Stimulus: write 0x3C to addr 0x3F, then read it.
   - Response: each transfer takes exactly 2 cycles; read returns 0x3C.
4. Out of range:
   - Stimulus: write 0xFF to addr 0x40 (DEPTH=64), then read 0x40 and read 0x00.
   - Response: PSLVERR=1 with PREADY on both 0x40 accesses; 0x40 read gives PRDATA=0; addr 0x00 is unchanged.
5. Abort:
   - Stimulus: write 0x77 to addr 0x05 (prior content 0x11); drop PSEL in the 1st wait cycle.
   - Response: no PREADY pulse; busy=0 next cycle; a read of 0x05 returns 0x11.
6. Back-to-back:
   - Stimulus: four consecutive writes to 0x00..0x03 with no idle gaps, then read-back.
   - Response: every write is accepted; read-back values match; PREADY never overlaps the setup phase.

Source files
------------

// File: rtl/apb_sram_completer_pkg.sv
// Shared types and constants for the APB SRAM completer.
// Provides the FSM state enum, default bus widths and error read data.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam int APB_ADDR_W    = 8;
  localparam int APB_DATA_W    = 8;
  localparam int APB_ERR_RDATA = 0;

endpackage

// File: rtl/apb_sram_completer_if.sv
// APB3 bus bundle between the requester (master) and completer (slave).
// Signals: PSEL PENABLE PWRITE PADDR PWDATA / PREADY PRDATA PSLVERR.
interface apb_sram_completer_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_sram_completer_sram_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one combinational
// read port. Ports: clk, we, waddr, wdata, raddr, rdata. Not reset.
module apb_sram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  // Out-of-range reads return zero instead of aliasing a real word.
  always_comb begin
    rdata = '0;
    if ({1'b0, raddr} < DEPTH_L) begin
      rdata = mem[raddr[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/apb_sram_completer.sv
// APB3 SRAM completer with optional wait states (macro APB_WAIT_EN).
// Ports: PCLK, PRESET (async high), apb (slave modport), busy.
module apb_sram_completer
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_sram_completer_if.slave  apb,
  output logic                 busy
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] ERR_D = DATA_W'(APB_ERR_RDATA);
`ifdef APB_WAIT_EN
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
`else
  // Without the counter every access completes in its first cycle.
  localparam bit ZERO_WAIT = 1'b1 | (WAIT_CYCLES == 0);
`endif

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;
`ifdef APB_WAIT_EN
  logic [3:0]        cnt;
`endif

  logic              setup;
  logic              err_in;
  logic              done;
  logic              we;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;

  assign setup  = apb.PSEL & ~apb.PENABLE;
  assign err_in = ({1'b0, apb.PADDR} >= DEPTH_L);
  // A zero-wait setup edge loads read data, so look at the live address.
  assign raddr  = setup ? apb.PADDR : addr_q;
  assign done   = (state == ACCESS) & apb.PSEL
                & apb.PENABLE & pready;
  assign we     = done & wr_q & ~err_q;

  apb_sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (PCLK),
    .we    (we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      busy    <= 1'b0;
`ifdef APB_WAIT_EN
      cnt     <= '0;
`endif
    end else if (setup) begin
      // Setup from IDLE, or a restart while in ACCESS.
      state   <= ACCESS;
      addr_q  <= apb.PADDR;
      wr_q    <= apb.PWRITE;
      wdata_q <= apb.PWDATA;
      err_q   <= err_in;
      busy    <= 1'b1;
      pready  <= ZERO_WAIT;
      pslverr <= ZERO_WAIT & err_in;
      if (ZERO_WAIT && !apb.PWRITE) begin
        prdata <= err_in ? ERR_D : rdata;
      end
`ifdef APB_WAIT_EN
      cnt     <= WAIT_L;
`endif
    end else if (state == ACCESS) begin
      // Here PSEL=1 implies PENABLE=1, so pready means completion.
      if (!apb.PSEL || pready) begin
        state   <= IDLE;
        pready  <= 1'b0;
        pslverr <= 1'b0;
        busy    <= 1'b0;
      end
`ifdef APB_WAIT_EN
      else begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          pready  <= 1'b1;
          pslverr <= err_q;
          if (!wr_q) begin
            prdata <= err_q ? ERR_D : rdata;
          end
        end
      end
`endif
    end
  end

  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pslverr;
  assign apb.PRDATA  = prdata;

endmodule
